// File: rtl/ram_integrity_master.sv
// rtl/ram_integrity_master.sv - Avalon-MM initiator folding a RAM region into a rotate-add checksum.
// Optional zeroize mode (mode=1 clears the region) is built only when RAM_INTEGRITY_ZEROIZE_EN is defined.
module ram_integrity_master #(
  parameter int          ADDR_W = 15,
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] expected,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              aborted,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued;
  logic [DATA_W-1:0] expected_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic              rd_valid;
  logic              zero_q;
  logic              zero_sel;

`ifdef RAM_INTEGRITY_ZEROIZE_EN
  assign zero_sel = mode;
`else
  logic unused_mode;
  assign zero_sel    = 1'b0;
  assign unused_mode = mode;
`endif

  assign byteenable = 4'hF;
  assign writedata  = '0;

  // Slave returns data one cycle after the address, so rd_valid marks the cycle readdata belongs to us.
  always_comb begin
    acc_next = acc;
    if (rd_valid) acc_next = {acc[DATA_W-2:0], acc[DATA_W-1]} + readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
      aborted    <= 1'b0;
      result     <= SEED;
      address    <= '0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      len_q      <= '0;
      issued     <= '0;
      expected_q <= '0;
      acc        <= SEED;
      rd_valid   <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      done     <= 1'b0;
      aborted  <= 1'b0;
      rd_valid <= chipselect & ~write;
      acc      <= acc_next;
      if (abort && (state == RUN || state == DRAIN)) begin
        state      <= IDLE;
        busy       <= 1'b0;
        chipselect <= 1'b0;
        write      <= 1'b0;
        aborted    <= 1'b1;
        rd_valid   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len_q      <= len;
              expected_q <= expected;
              zero_q     <= zero_sel;
              acc        <= SEED;
              issued     <= {{ADDR_W{1'b0}}, 1'b1};
              if (len != '0) begin
                state      <= RUN;
                busy       <= 1'b1;
                chipselect <= 1'b1;
                write      <= zero_sel;
                address    <= base;
              end else begin
                state  <= DONE;
                done   <= 1'b1;
                result <= zero_sel ? '0 : SEED;
                match  <= zero_sel ? 1'b1 : (SEED == expected);
              end
            end
          end
          RUN: begin
            if (issued == len_q) begin
              chipselect <= 1'b0;
              write      <= 1'b0;
              if (zero_q) begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= {{(DATA_W-ADDR_W-1){1'b0}}, issued};
                match  <= (issued == len_q);
              end else begin
                state <= DRAIN;
              end
            end else begin
              address <= address + 1'b1;
              issued  <= issued + 1'b1;
            end
          end
          DRAIN: begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_next;
            match  <= (acc_next == expected_q);
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_integrity_master.sv
// tb/tb_ram_integrity_master.sv - Randomized bench for ram_integrity_master against a timeline model.
module tb_ram_integrity_master;

  localparam logic [31:0] SEED = 32'h0000_0000;
`ifdef RAM_INTEGRITY_ZEROIZE_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif
  localparam int PH_IDLE = 0, PH_OP = 1, PH_TAIL = 2;

  logic        clk = 1'b0;
  logic        reset, start, abort, mode;
  logic [14:0] base;
  logic [15:0] len;
  logic [31:0] expected;
  logic        busy, done, match, aborted, chipselect, write;
  logic [31:0] result, writedata, readdata;
  logic [14:0] address;
  logic [3:0]  byteenable;

  logic        tb_we;
  logic [14:0] tb_waddr;
  logic [31:0] tb_wdata;

  bit [31:0] mem     [0:32767];
  bit [31:0] ref_mem [0:32767];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_integrity_master #(.ADDR_W(15), .DATA_W(32), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .base(base), .len(len), .expected(expected),
    .busy(busy), .done(done), .match(match), .aborted(aborted), .result(result),
    .address(address), .chipselect(chipselect), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata)
  );

  // RAM slave: read latency 1, no waitrequest; the bench preloads through tb_we.
  always_ff @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    if (chipselect && write) mem[address] <= writedata;
    if (chipselect && !write) readdata <= mem[address];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] csum(input int b, input int l);
    logic [31:0] s = SEED;
    for (int j = 0; j < l; j++) s = {s[30:0], s[31]} + ref_mem[(b + j) % 32768];
    return s;
  endfunction

  // Model state: an operation is a timeline counted in edges since its accepted start.
  int          ph = PH_IDLE, k = 0, fin = 0, o_base = 0, o_len = 0;
  logic [31:0] o_exp = 0, o_sum = 0, m_res = SEED;
  bit          o_zero = 0, m_match = 0, m_done = 0, m_abrt = 0, m_busy = 0, m_cs = 0, m_wr = 0, m_rst = 0;
  int          m_addr = 0;
  logic        p_rst = 1'b1, p_start = 0, p_abort = 0, p_mode = 0, p_we = 0;
  logic [14:0] p_base = 0, p_waddr = 0;
  logic [15:0] p_len = 0;
  logic [31:0] p_exp = 0, p_wdata = 0;

  task automatic finish_op();
    m_done  = 1'b1;
    m_res   = o_sum;
    m_match = o_zero ? (o_sum == o_len) : (o_sum == o_exp);
    ph      = PH_TAIL;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      m_done = 0; m_abrt = 0; m_rst = 0;
      if (p_we) ref_mem[p_waddr] = p_wdata;
      if (p_rst) begin
        ph = PH_IDLE; m_res = SEED; m_match = 0; m_rst = 1;
      end else if (ph == PH_IDLE) begin
        if (p_start) begin
          o_base = int'(p_base); o_len = int'(p_len); o_exp = p_exp;
          o_zero = ZEN && p_mode; k = 0;
          if (o_zero) begin o_sum = o_len; fin = o_len; end
          else begin o_sum = csum(o_base, o_len); fin = o_len + 1; end
          if (o_len == 0) fin = 0;
          if (fin == 0) finish_op(); else ph = PH_OP;
        end
      end else if (ph == PH_OP) begin
        k++;
        if (p_abort) begin m_abrt = 1; ph = PH_IDLE; end
        else if (k == fin) finish_op();
      end else begin
        ph = PH_IDLE;
      end
      m_busy = (ph == PH_OP);
      m_cs   = (ph == PH_OP) && (k < o_len);
      m_addr = m_cs ? (o_base + k) % 32768 : 0;
      m_wr   = m_cs && o_zero;
      if (m_wr) ref_mem[m_addr] = 32'h0;

      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("aborted", aborted, m_abrt);
      chk("chipselect", chipselect, m_cs);
      chk("write", write, m_wr);
      chk("byteenable", byteenable, 4'hF);
      chk("writedata", writedata, 32'h0);
      chk("result", result, m_res);
      chk("match", match, m_match);
      if (m_cs || m_rst) chk("address", address, m_addr);

      p_rst = reset; p_start = start; p_abort = abort; p_mode = mode;
      p_base = base; p_len = len; p_exp = expected;
      p_we = tb_we; p_waddr = tb_waddr; p_wdata = tb_wdata;
    end
  end

  task automatic poke(input int a, input logic [31:0] d);
    @(posedge clk); #2;
    tb_we = 1'b1; tb_waddr = a[14:0]; tb_wdata = d;
    @(posedge clk); #2;
    tb_we = 1'b0;
  endtask

  task automatic run_dir(input string nm, input int b, input int l, input logic [31:0] e,
                         input bit m, input bit ab, input logic [31:0] xr, input bit xm, input int lat);
    int got = -1;
    @(posedge clk); #2;
    start = 1'b1; abort = ab; mode = m; base = b[14:0]; len = l[15:0]; expected = e;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = c; break; end
    end
    chk({nm, "_latency"}, got, lat);
    @(negedge clk);
    chk({nm, "_result"}, result, xr);
    chk({nm, "_match"}, match, {31'b0, xm});
  endtask

  initial begin
    int          rb, rl;
    logic [31:0] re;
    bit          rm;
    reset = 1'b1; start = 0; abort = 0; mode = 0; base = 0; len = 0; expected = 0;
    tb_we = 0; tb_waddr = 0; tb_wdata = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_chipselect", chipselect, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, SEED);
    chk("rst_address", address, 0);
    chk("rst_byteenable", byteenable, 4'hF);

    poke(0, 1); poke(1, 2); poke(2, 3);
    run_dir("sum3", 0, 3, 32'hB, 0, 0, 32'hB, 1, 4);
    run_dir("sum3_bad", 0, 3, 32'hC, 0, 0, 32'hB, 0, 4);
    run_dir("len0", 5, 0, 32'h0, 0, 0, SEED, 1, 0);

    @(posedge clk); #2;
    start = 1'b1; base = 0; len = 100; expected = 0; mode = 0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_pulse", aborted, 1);
    chk("abort_cs", chipselect, 0);
    chk("abort_held_result", result, SEED);
    chk("abort_held_match", match, 1);
    run_dir("after_abort", 0, 3, 32'hB, 0, 0, 32'hB, 1, 4);

    poke(32766, 1); poke(32767, 1); poke(0, 1); poke(1, 1);
    run_dir("wrap", 32766, 4, 32'hF, 0, 1, 32'hF, 1, 5);

    @(posedge clk); #2;
    start = 1'b1; base = 15'd100; len = 50; expected = 0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_cs", chipselect, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, SEED);
    chk("midrst_match", match, 0);

`ifdef RAM_INTEGRITY_ZEROIZE_EN
    for (int j = 0; j < 8; j++) poke(16 + j, 32'h100 + j);
    run_dir("zeroize", 16, 8, 32'h0, 1, 0, 32'd8, 1, 8);
    run_dir("zero_sum", 16, 8, 32'h0, 0, 0, 32'h0, 1, 9);
`endif

    for (int j = 0; j < 64; j++) poke(32704 + j, $urandom);
    for (int j = 0; j < 64; j++) poke(j, $urandom);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 32767);
        1:       rb = $urandom_range(0, 30);
        default: rb = $urandom_range(32704, 32767);
      endcase
      rl = $urandom_range(0, 40);
      re = $urandom_range(0, 1) ? csum(rb, rl) : $urandom;
      rm = ($urandom_range(0, 5) == 0);
      @(posedge clk); #2;
      start = 1'b1; mode = rm; base = rb[14:0]; len = rl[15:0]; expected = re;
      abort = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < rl + 4; c++) begin
        @(posedge clk); #2;
        start = ($urandom_range(0, 60) == 0);
        abort = ($urandom_range(0, 40) == 0);
      end
      @(posedge clk); #2;
      start = 1'b0; abort = 1'b0;
    end
    repeat (60) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_integrity_master.md
Name: ram_integrity_master

Overview:
- Avalon-MM initiator that drives the 32K x 32 single-port on-chip security RAM slave.
- On a start command it streams reads over a word-addressed region and folds each word into a rotate-add checksum.
- It compares the checksum against an expected value and reports match/mismatch to the security controller.
- Sits between the security control logic and the RAM slave's s1/s2 port; the slave has fixed read latency 1 and no waitrequest.

Parameters:
- ADDR_W, 15, word address width of the RAM slave.
- DATA_W, 32, data width; fixed at 32 for checksum definition.
- SEED, 32'h0000_0000, initial accumulator value.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle command strobe; honoured only in IDLE.
- abort  in  1  terminates an operation in progress.
- mode  in  1  0 = checksum, 1 = zeroize (see Optional Feature).
- base  in  ADDR_W  first word address, sampled on accepted start.
- len  in  ADDR_W+1  number of words, 0..32768, sampled on accepted start.
- expected  in  32  reference checksum, sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle completion pulse.
- match  out  1  result == expected; valid with done, held until the next start.
- aborted  out  1  one-cycle pulse when abort takes effect.
- result  out  32  final checksum, or word count in zeroize mode; held until the next start.
- address  out  ADDR_W  Avalon address to RAM.
- chipselect  out  1  Avalon chipselect.
- write  out  1  Avalon write.
- byteenable  out  4  Avalon byteenable; always 4'hF.
- writedata  out  32  Avalon writedata; always 0.
- readdata  in  32  Avalon readdata; valid 1 cycle after a read address.

Behaviour:
- Reset values:
  - busy, done, match, aborted, chipselect, write = 0.
  - result = SEED.
  - address = 0, byteenable = 4'hF, writedata = 0.
  - FSM = IDLE; any transfer in flight is dropped, with no done or aborted pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 captures base, len, expected, mode; acc <= SEED; issue counter <= 0.
  - If len != 0, go to RUN; if len == 0, go to DONE directly with no bus access.
- RUN:
  - Each cycle: chipselect=1, address = (base + i) mod 2^ADDR_W, i increments.
  - One read per cycle, back-to-back; the address wraps from 0x7FFF to 0x0000.
  - After issuing word len-1, go to DRAIN.
- Read pipeline:
  - A valid bit is delayed one cycle from each issued read.
  - When set, acc <= {acc[30:0], acc[31]} + readdata (mod 2^32).
- DRAIN: chipselect=0; waits one cycle for the final readdata, then goes to DONE.
- DONE:
  - done=1 for one cycle; result <= acc; match <= (acc == expected); busy=0.
  - Returns to IDLE.
- Latency: start accepted at edge T gives first address at T+1 and done at T+len+2 (T+1 for len=0).
- abort:
  - Effective in RUN or DRAIN: next cycle chipselect=0, pending readdata discarded, aborted=1 for one cycle.
  - Goes to IDLE; result and match keep their previous values.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored. start and abort together in IDLE: start wins.

Optional Feature:
- Macro: RAM_INTEGRITY_ZEROIZE_EN.
- Defined:
  - mode=1 selects zeroize. RUN drives chipselect=1, write=1, byteenable=4'hF, writedata=0, one word per cycle over the region.
  - No read pipeline is used; DRAIN is skipped (RUN goes to DONE).
  - result = number of words written; match = 1 if result == len.
  - Latency: done at T+len+1. abort behaves as in checksum mode.
- Not defined: mode is ignored, every operation is a checksum, and write stays 0.

Test Plan:
- RAM[0..2]=1,2,3; start base=0 len=3 expected=0xB -> addresses 0,1,2 on consecutive cycles, done at T+5, result=0x0000000B, match=1.
- Same region, expected=0xC -> result=0xB, match=0.
- base=0x7FFE len=4 with RAM[0x7FFE]=RAM[0x7FFF]=RAM[0]=RAM[1]=1 -> addresses 7FFE,7FFF,0000,0001; result=0xF.
- len=0 -> no chipselect; done at T+1; result=SEED; match=(SEED==expected).
- Abort during RUN of a len=100 operation, then a new len=3 start -> aborted pulse, no done, previous result held; new result=0xB. Reset asserted mid-RUN -> chipselect=0 next cycle, all outputs at reset values.
- RAM_INTEGRITY_ZEROIZE_EN defined, mode=1, base=0x10 len=8 -> write=1 at addresses 0x10..0x17 with writedata=0; done at T+9; result=8; match=1. Follow-up checksum over the same region -> result=0.
